// File: rtl/hb3_multi_ctrl_pkg.sv
// Shared types and helpers for the multi-channel H-bridge controller.
package hb3_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        COAST = 1'b1
    } chan_state_t;

    // Number of bits needed to hold any value from 0 up to max_val (at least one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hb3_multi_ctrl_if.sv
// Processor/PMOD-facing signal bundle of the H-bridge controller.
interface hb3_multi_ctrl_if #(
    parameter int NUM_CH    = 2,
    parameter int PWM_BITS  = 8,
    parameter int TACH_BITS = 16
);
    logic [NUM_CH-1:0]           enable;
    logic [NUM_CH-1:0]           dir_req;
    logic [NUM_CH*PWM_BITS-1:0]  duty;
    logic [NUM_CH-1:0]           sa;
    logic [NUM_CH-1:0]           sb;
    logic [NUM_CH-1:0]           en_out;
    logic [NUM_CH-1:0]           dir_out;
    logic [NUM_CH-1:0]           reversing;
    logic [NUM_CH*TACH_BITS-1:0] tach_count;
    logic [NUM_CH-1:0]           tach_dir;
    logic                        tach_valid;

    modport master (
        output enable, dir_req, duty, sa, sb,
        input  en_out, dir_out, reversing, tach_count, tach_dir, tach_valid
    );

    modport slave (
        input  enable, dir_req, duty, sa, sb,
        output en_out, dir_out, reversing, tach_count, tach_dir, tach_valid
    );
endinterface

// File: rtl/hb3_multi_ctrl_tach.sv
// Per-channel tachometer: synchronises SA/SB, counts SA rising edges with
// saturation and hands the count over on the shared gate strobe.
module hb3_tach #(
    parameter int TACH_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sa,
    input  logic                 sb,
    input  logic                 gate,
    output logic [TACH_BITS-1:0] count,
    output logic                 dir
);
    logic [1:0]           sa_sync_q, sa_sync_d;
    logic [1:0]           sb_sync_q, sb_sync_d;
    logic                 sa_prev_q, sa_prev_d;
    logic [TACH_BITS-1:0] rise_cnt_q, rise_cnt_d;
    logic [TACH_BITS-1:0] count_q, count_d;
    logic                 dir_q, dir_d;
    logic                 sa_rise;
    logic [TACH_BITS-1:0] rise_inc;

    // Synchroniser, edge register, edge counter and window results
    always_ff @(posedge clk) begin
        if (reset) begin
            sa_sync_q  <= '0;
            sb_sync_q  <= '0;
            sa_prev_q  <= 1'b0;
            rise_cnt_q <= '0;
            count_q    <= '0;
            dir_q      <= 1'b0;
        end else begin
            sa_sync_q  <= sa_sync_d;
            sb_sync_q  <= sb_sync_d;
            sa_prev_q  <= sa_prev_d;
            rise_cnt_q <= rise_cnt_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
        end
    end

    // An edge arriving on the gate cycle still belongs to the window being closed
    always_comb begin
        sa_sync_d = {sa_sync_q[0], sa};
        sb_sync_d = {sb_sync_q[0], sb};
        sa_prev_d = sa_sync_q[1];
        sa_rise   = sa_sync_q[1] & ~sa_prev_q;
        rise_inc  = (sa_rise && (rise_cnt_q != '1)) ? rise_cnt_q + 1'b1 : rise_cnt_q;
        dir_d     = sa_rise ? sb_sync_q[1] : dir_q;
        if (gate) begin
            count_d    = rise_inc;
            rise_cnt_d = '0;
        end else begin
            count_d    = count_q;
            rise_cnt_d = rise_inc;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;

endmodule

// File: rtl/hb3_multi_ctrl.sv
// N-channel H-bridge controller: shared PWM timebase and tach gate, per-channel
// RUN/COAST reversal FSM with dead-time, and per-channel tachometers.
module hb3_multi_ctrl
    import hb3_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int PWM_BITS     = 8,
    parameter int PWM_DIV      = 390,
    parameter int DEADTIME_CYC = 1_000_000,
    parameter int GATE_CYC     = 10_000_000,
    parameter int TACH_BITS    = 16
) (
    input logic             clk,
    input logic             reset,
    hb3_multi_ctrl_if.slave bus
);
    localparam int PRE_W  = cnt_width(PWM_DIV - 1);
    localparam int GATE_W = cnt_width(GATE_CYC - 1);
    localparam int DT_W   = cnt_width(DEADTIME_CYC);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYC - 1);
    localparam logic [DT_W-1:0]     DT_LOAD   = DT_W'(DEADTIME_CYC);
    localparam logic [DT_W-1:0]     DT_ONE    = DT_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic                tach_valid_q, tach_valid_d;
    logic                pwm_tick, pwm_wrap, gate_strobe;

    logic [NUM_CH-1:0]           en_vec, dir_vec, rev_vec, tach_dir_vec;
    logic [NUM_CH*TACH_BITS-1:0] tach_count_vec;

    // Shared timebase registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q        <= '0;
            pwm_cnt_q    <= '0;
            gate_q       <= '0;
            tach_valid_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            pwm_cnt_q    <= pwm_cnt_d;
            gate_q       <= gate_d;
            tach_valid_q <= tach_valid_d;
        end
    end

    // Prescaler tick steps the PWM counter; gate counter closes a window on its last count
    always_comb begin
        pwm_tick     = (pre_q == PRE_LAST);
        pwm_wrap     = pwm_tick && (pwm_cnt_q == PWM_MAX);
        gate_strobe  = (gate_q == GATE_LAST);
        pre_d        = pwm_tick ? '0 : pre_q + 1'b1;
        pwm_cnt_d    = pwm_tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        gate_d       = gate_strobe ? '0 : gate_q + 1'b1;
        tach_valid_d = gate_strobe;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_state_t         state_q, state_d;
        logic [DT_W-1:0]     dt_q, dt_d;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic                dir_q, dir_d;
        logic                en_q, en_d;
        logic                rev_q, rev_d;

        // Channel state register with registered EN/reversing outputs
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= RUN;
                dt_q    <= '0;
                duty_q  <= '0;
                dir_q   <= 1'b0;
                en_q    <= 1'b0;
                rev_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dt_q    <= dt_d;
                duty_q  <= duty_d;
                dir_q   <= dir_d;
                en_q    <= en_d;
                rev_q   <= rev_d;
            end
        end

        // Reversal request starts a fixed coast; dir_req is only re-read when it ends
        always_comb begin
            state_d = state_q;
            dt_d    = dt_q;
            dir_d   = dir_q;
            duty_d  = pwm_wrap ? bus.duty[i*PWM_BITS +: PWM_BITS] : duty_q;
            case (state_q)
                RUN: begin
                    if (bus.dir_req[i] != dir_q) begin
                        state_d = COAST;
                        dt_d    = DT_LOAD;
                    end
                end
                COAST: begin
                    if (dt_q == DT_ONE) begin
                        state_d = RUN;
                        dir_d   = bus.dir_req[i];
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // EN follows the PWM compare only while running; reversing marks the coast
        always_comb begin
            en_d  = bus.enable[i] && (state_q == RUN) && (pwm_cnt_q < duty_q);
            rev_d = (state_q == COAST);
        end

        assign en_vec[i]  = en_q;
        assign dir_vec[i] = dir_q;
        assign rev_vec[i] = rev_q;

        hb3_tach #(
            .TACH_BITS(TACH_BITS)
        ) u_tach (
            .clk  (clk),
            .reset(reset),
            .sa   (bus.sa[i]),
            .sb   (bus.sb[i]),
            .gate (gate_strobe),
            .count(tach_count_vec[i*TACH_BITS +: TACH_BITS]),
            .dir  (tach_dir_vec[i])
        );
    end

    assign bus.en_out     = en_vec;
    assign bus.dir_out    = dir_vec;
    assign bus.reversing  = rev_vec;
    assign bus.tach_count = tach_count_vec;
    assign bus.tach_dir   = tach_dir_vec;
    assign bus.tach_valid = tach_valid_q;

endmodule

// File: tb/tb_hb3_multi_ctrl.sv
// Directed bench for hb3_multi_ctrl: PWM pattern table plus hand-written
// reversal, tachometer, saturation and reset sequences.
module tb_hb3_multi_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Bench-side cycle count since reset release, used to find PWM period boundaries
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    hb3_multi_ctrl_if #(.NUM_CH(2), .PWM_BITS(4), .TACH_BITS(3)) bus ();

    hb3_multi_ctrl #(
        .NUM_CH(2), .PWM_BITS(4), .PWM_DIV(1),
        .DEADTIME_CYC(8), .GATE_CYC(100), .TACH_BITS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        en;
        logic [3:0]  duty;
        logic [3:0]  mid_duty;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } pwm_vec_t;

    pwm_vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [1:0] dr,
                                 input logic [3:0] d0, input logic [3:0] d1);
        bus.enable  = en;
        bus.dir_req = dr;
        bus.duty    = {d1, d0};
    endtask

    task automatic waitValid(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tach_valid !== 1'b1 && n < limit);
        if (bus.tach_valid !== 1'b1) n = -1;
    endtask

    task automatic saPulses(input int ch, input int count);
        for (int p = 0; p < count; p++) begin
            bus.sa[ch] = 1'b1;
            tick(2);
            bus.sa[ch] = 1'b0;
            tick(2);
        end
    endtask

    task automatic alignPeriod();
        @(negedge clk);
        while (cyc % 16 != 0) @(negedge clk);
    endtask

    // Watchdog so a stuck run still ends with a report
    initial begin
        #500us;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] pat_a, pat_b;
        int n;

        vecs[0] = '{1'b1, 4'd4,  4'd12, 16'h000F, 16'h0FFF};
        vecs[1] = '{1'b1, 4'd0,  4'd0,  16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 4'd15, 4'd15, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{1'b0, 4'd8,  4'd8,  16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 4'd8,  4'd3,  16'h00FF, 16'h0007};

        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        bus.sa = 2'b00;
        bus.sb = 2'b00;
        tick(3);
        checkOutput("rst_en_out", bus.en_out, 0);
        checkOutput("rst_dir_out", bus.dir_out, 0);
        checkOutput("rst_reversing", bus.reversing, 0);
        checkOutput("rst_tach_count", bus.tach_count, 0);
        checkOutput("rst_tach_dir", bus.tach_dir, 0);
        checkOutput("rst_tach_valid", bus.tach_valid, 0);
        reset = 1'b0;

        // PWM table: period A captures the starting duty (changed to mid_duty at phase 5), period B the new one
        for (int v = 0; v < 5; v++) begin
            applyStimulus({1'b0, vecs[v].en}, 2'b00, vecs[v].duty, 4'd0);
            alignPeriod();
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                pat_a[j] = bus.en_out[0];
                if (j == 5) bus.duty[3:0] = vecs[v].mid_duty;
            end
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                pat_b[j] = bus.en_out[0];
            end
            checkOutput($sformatf("pwm%0d_period_a", v), pat_a, vecs[v].exp_a);
            checkOutput($sformatf("pwm%0d_period_b", v), pat_b, vecs[v].exp_b);
        end

        // Reversal on channel 1 at duty 8, started at a period boundary
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd8);
        alignPeriod();
        bus.dir_req[1] = 1'b1;
        tick(1);
        checkOutput("rev_en_before", bus.en_out[1], 1);
        checkOutput("rev_not_yet", bus.reversing[1], 0);
        tick(1);
        checkOutput("rev_reversing", bus.reversing[1], 1);
        checkOutput("rev_en_off", bus.en_out[1], 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (bus.en_out[1] !== 1'b0) n++;
        end
        checkOutput("rev_en_quiet", n, 0);
        checkOutput("rev_dir_held", bus.dir_out[1], 0);
        tick(1);
        checkOutput("rev_dir_flip", bus.dir_out[1], 1);
        checkOutput("rev_still_rev", bus.reversing[1], 1);
        tick(1);
        checkOutput("rev_done", bus.reversing[1], 0);

        // Toggle dir_req back during coast: no restart, direction unchanged
        bus.dir_req[1] = 1'b0;
        tick(3);
        bus.dir_req[1] = 1'b1;
        tick(6);
        checkOutput("tog_rev_last", bus.reversing[1], 1);
        tick(1);
        checkOutput("tog_rev_end", bus.reversing[1], 0);
        checkOutput("tog_dir_same", bus.dir_out[1], 1);
        bus.enable = 2'b00;

        // Tach: 7 pulses with sb=1 inside one window
        waitValid(n, 250);
        checkOutput("tach_align", (n > 0), 1);
        bus.sb[0] = 1'b1;
        saPulses(0, 7);
        waitValid(n, 200);
        checkOutput("tach_period", 28 + n, 100);
        checkOutput("tach_count7", bus.tach_count[2:0], 7);
        checkOutput("tach_dir1", bus.tach_dir[0], 1);
        checkOutput("tach_ch1_zero", bus.tach_count[5:3], 0);
        tick(1);
        checkOutput("tach_valid_pulse", bus.tach_valid, 0);

        // Edge landing on the gate's final cycle belongs to the closing window
        tick(96);
        bus.sa[0] = 1'b1;
        bus.sb[0] = 1'b0;
        tick(2);
        bus.sa[0] = 1'b0;
        tick(1);
        checkOutput("gate_valid", bus.tach_valid, 1);
        checkOutput("gate_count", bus.tach_count[2:0], 1);
        checkOutput("gate_dir0", bus.tach_dir[0], 0);
        waitValid(n, 200);
        checkOutput("gate_next_period", n, 100);
        checkOutput("gate_next_zero", bus.tach_count[2:0], 0);

        // Saturation on ch0 and an independent count on ch1
        bus.sb[1] = 1'b1;
        saPulses(1, 2);
        saPulses(0, 10);
        waitValid(n, 200);
        checkOutput("sat_count0", bus.tach_count[2:0], 7);
        checkOutput("sat_count1", bus.tach_count[5:3], 2);
        checkOutput("sat_dir1", bus.tach_dir[1], 1);

        // Reset asserted mid-coast clears everything and restarts the gate window
        applyStimulus(2'b01, 2'b01, 4'd15, 4'd0);
        tick(3);
        checkOutput("rst_mid_coast", bus.reversing[0], 1);
        reset = 1'b1;
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        bus.dir_req[1] = 1'b0;
        tick(1);
        checkOutput("rst2_en_out", bus.en_out, 0);
        checkOutput("rst2_dir_out", bus.dir_out, 0);
        checkOutput("rst2_reversing", bus.reversing, 0);
        checkOutput("rst2_tach_count", bus.tach_count, 0);
        checkOutput("rst2_tach_dir", bus.tach_dir, 0);
        checkOutput("rst2_tach_valid", bus.tach_valid, 0);
        reset = 1'b0;
        waitValid(n, 300);
        checkOutput("rst2_first_valid", n, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hb3_multi_ctrl.md
# hb3_multi_ctrl

Parametrised N-channel H-bridge (HB3-style) motor controller with tachometer feedback. It sits between the embedded processor's GPIO/register interface and the PMOD motor headers.
- Per channel: registered PWM enable, direction output with a mandatory coast dead-time before any reversal, and a gated tachometer that counts SA rising edges and samples SB for measured rotation direction.
- It generalises the single-channel DIR/EN/SA/SB hookup to NUM_CH channels, with configurable PWM resolution and measurement window.

## Interface
Parameters:
- NUM_CH, 2, number of motor channels
- PWM_BITS, 8, PWM counter/duty width
- PWM_DIV, 390, clocks per PWM counter step (≈1 kHz PWM at 100 MHz, 8 bits); must be ≥1
- DEADTIME_CYC, 1_000_000, coast cycles before a direction change (10 ms); must be ≥1
- GATE_CYC, 10_000_000, tachometer gate window in clocks (100 ms)
- TACH_BITS, 16, tach count width

Ports:
- clk  in  1  system clock (100 MHz); one clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  NUM_CH  per-channel run enable
- dir_req  in  NUM_CH  requested direction
- duty  in  NUM_CH*PWM_BITS  per-channel duty; channel i at [i*PWM_BITS +: PWM_BITS]
- sa  in  NUM_CH  tach A (asynchronous)
- sb  in  NUM_CH  tach B (asynchronous)
- en_out  out  NUM_CH  H-bridge EN (PWM)
- dir_out  out  NUM_CH  H-bridge DIR
- reversing  out  NUM_CH  high while channel is in COAST
- tach_count  out  NUM_CH*TACH_BITS  SA rising edges in the last gate window
- tach_dir  out  NUM_CH  SB level sampled at the most recent SA rising edge
- tach_valid  out  1  one-cycle pulse when every tach_count updates

## Operation
- Reset values: en_out=0, dir_out=0, reversing=0, tach_count=0, tach_dir=0, tach_valid=0, all counters 0, every channel in RUN.
- PWM:
  - Shared prescaler produces a tick every PWM_DIV clocks.
  - Shared pwm_cnt increments on each tick and wraps from 2^PWM_BITS-1 to 0.
  - Each channel latches duty into duty_q on the tick where pwm_cnt wraps to 0, so mid-period changes never glitch.
  - en_out = enable & (state==RUN) & (pwm_cnt < duty_q), registered.
  - duty 0 → en_out constantly 0. Maximum duty → high for (2^PWM_BITS-1)/2^PWM_BITS of the period.
- Per-channel FSM, states RUN and COAST:
  - RUN→COAST when dir_req != dir_out. This is evaluated regardless of enable. The dead-time counter loads DEADTIME_CYC.
  - In COAST: en_out=0, reversing=1, and the counter decrements each cycle.
  - At counter==1: dir_out ← current dir_req, state → RUN. If dir_req has toggled back, dir_out is unchanged and the channel simply returns to RUN.
  - dir_req changes during COAST do not restart the dead-time.
- Tachometer:
  - sa and sb each pass through a 2-flop synchroniser, then a registered rising-edge detect on sa.
  - Each SA edge increments the channel edge counter, saturating at all-ones, and captures tach_dir ← synchronised sb.
  - A shared gate counter runs 0..GATE_CYC-1. When it reaches GATE_CYC-1:
    - every tach_count ← its edge counter (including any edge in that same cycle);
    - edge counters clear to 0;
    - tach_valid pulses for one cycle.
- Reset asserted mid-operation (mid-COAST, mid-window) returns everything to reset values on the next edge; no partial window is reported.

## Timing
- duty → en_out: takes effect at the first PWM period start after the change; en_out is 1 clock behind the compare.
- dir_req mismatch sampled at edge N → reversing=1 and en_out=0 after edge N+1.
  - dir_out updates exactly DEADTIME_CYC cycles later.
  - en_out may reassert on the following compare.
  - en_out and dir_out never change in the same cycle.
- sa rising edge at pin → counted 3 clocks later (2 sync + edge register).
- First tach_valid occurs GATE_CYC cycles after reset deasserts, then every GATE_CYC cycles.

## Structure
- Package hb3_pkg holds:
  - chan_state_t enum {RUN, COAST};
  - helper for counter widths ($clog2 of PWM_DIV, DEADTIME_CYC, GATE_CYC).
- Sub-module hb3_tach (one instance per channel) contains the synchronisers, edge detect, saturating edge counter and tach_dir capture. It takes the shared gate strobe as an input.
- PWM prescaler, pwm_cnt and gate counter are shared in the top.
- Per-channel PWM/FSM logic lives in a generate loop.

## Test plan
Bench parameters: NUM_CH=2, PWM_BITS=4, PWM_DIV=1, DEADTIME_CYC=8, GATE_CYC=100.
- Duty: ch0 duty=4, enable=1 → en_out[0] high 4 of every 16 cycles. Change duty to 12 mid-period → old pattern holds until wrap, then 12/16.
- Duty extremes: duty=0 → en_out 0 always. duty=15 → high 15/16.
- Reversal: flip dir_req[1] while ch1 runs at duty 8 → en_out[1]=0 and reversing[1]=1 next cycle; dir_out[1] flips exactly 8 cycles later. Toggle dir_req back during COAST → dir_out unchanged, no dead-time restart.
- Tach: 7 SA pulses on ch0 with sb=1 inside one window → tach_count[0]=7, tach_dir[0]=1 at tach_valid. An SA edge on the gate's final cycle is counted in the closing window.
- Saturation and reset: with TACH_BITS=3, 10 edges in one window → tach_count=7. Assert reset mid-COAST → all outputs 0, and the next tach_valid comes 100 cycles after release.
